i2c_xfer_ctrl: RTL and testbench
================================

# i2c_xfer_ctrl

Transfer controller placed directly upstream of the I2C byte master. It accepts one transfer command at a time from a host and launches it on the master's enable/parameter inputs. Write data is supplied to the master from a TX FIFO, and read data is collected from the master into an RX FIFO. Each transfer ends with a completion pulse plus short-count, underrun and overflow status.

## Interface
- FIFO_AW, 4: FIFO address width; TX and RX depth = 2^FIFO_AW entries each.
- clock_i  in  1  system clock; same clock as the I2C master.
- rstn_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high in IDLE only; command accepted when valid & ready.
- cmd_rw_i  in  1  1 = read, 0 = write.
- cmd_ur_i  in  1  use register address (reads only; writes always send it).
- cmd_devadr_i  in  7  slave address.
- cmd_regadr_i  in  8  register address.
- cmd_len_i  in  16  byte count; 0 is illegal.
- tx_wr_i / tx_wdat_i  in  1 / 8  TX FIFO push.
- tx_full_o  out  1  TX FIFO full.
- tx_level_o  out  FIFO_AW+1  TX occupancy.
- rx_rd_i  in  1  RX FIFO pop.
- rx_rdat_o  out  8  RX FIFO head; valid while rx_empty_o = 0.
- rx_empty_o  out  1  RX FIFO empty.
- rx_level_o  out  FIFO_AW+1  RX occupancy.
- done_o  out  1  one-cycle completion pulse.
- err_short_o, err_unf_o, err_ovf_o, err_len_o  out  1 each  status of the last transfer; held until the next accept.
- m_enable_o, m_rw_o, m_ur_o  out  1 each  to master enable_i, rw_i, ur_i.
- m_devadr_o / m_regadr_o / m_datnum_o  out  7 / 8 / 16  registered command fields.
- m_dat_o  out  8  to master dat_i: TX FIFO head.
- m_dat_i  in  8  from master dat_o.
- m_busy_i, m_dvalid_i, m_newdat_i  in  1 each  from master busy_o, dvalid_o, newdat_o.

## Operation
- States: IDLE, LAUNCH, RUN, FINISH.
- IDLE:
  - cmd_ready_o = 1.
  - On accept: register all command fields, clear all err_* flags and the byte counter.
  - If cmd_len_i = 0: set err_len_o, go to FINISH without launching.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - Write command: wait while the TX FIFO is empty. Then drive m_enable_o = 1 until m_busy_i is sampled high, then go to RUN.
  - Read command: launch immediately.
- RUN:
  - Rising edge of m_newdat_i (write) increments the byte counter and pops the TX FIFO.
  - Popping with the TX FIFO empty sets err_unf_o; the master then sends stale data.
  - Rising edge of m_dvalid_i (read) increments the byte counter and pushes m_dat_i into the RX FIFO.
  - Pushing with the RX FIFO full sets err_ovf_o and drops the byte.
  - Falling edge of m_busy_i goes to FINISH. If byte counter < len, set err_short_o (covers a NACK on address or data).
- FINISH: done_o = 1 for one cycle, then IDLE.
- Edges are detected with one registered copy of m_newdat_i, m_dvalid_i and m_busy_i.
- Host FIFO ports stay live in every state:
  - tx_wr_i while full is ignored.
  - rx_rd_i while empty is ignored.
  - A simultaneous push and pop on one FIFO keeps its level unchanged.
- m_dat_o always shows the TX head; the master samples it at start and after each newdat pulse.
- Byte counter is 16-bit and saturates at 0xFFFF.
- Known limitation: a NACK on the final written byte is not distinguishable from success.

## Timing
- Reset values:
  - State IDLE; all FIFOs empty.
  - cmd_ready_o = 1, rx_empty_o = 1, tx_full_o = 0, levels = 0.
  - m_enable_o = 0, done_o = 0, all err_* = 0.
  - m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o, m_dat_o = 0.
- Accept to m_enable_o high: 1 cycle (read, or write with TX non-empty).
- m_enable_o deasserts the cycle after m_busy_i is sampled high.
- Pop/push takes effect 1 cycle after the master strobe rises. Each strobe causes exactly one pop or push, regardless of pulse width.
- done_o fires 2 cycles after the m_busy_i falling edge.
- cmd_ready_o returns to 1 the cycle after done_o.
- A reset assertion mid-transfer immediately forces IDLE, drops m_enable_o and flushes both FIFOs. The master is reset separately.

## Test plan
- Write: devadr 0x50, reg 0x10, len 3; TX preloaded A1 A2 A3; model slave ACKs all -> 3 pops, slave sees A1 A2 A3, done_o with all err = 0, tx_level_o = 0.
- Read: ur = 1, len 4; slave returns 11 22 33 44 -> rx_level_o = 4, pops yield 11 22 33 44, err = 0.
- Address NACK on read of len 2 -> busy falls after 0 bytes, err_short_o = 1, rx_empty_o = 1.
- Read len 20 with FIFO_AW = 4 and no host pops -> 16 bytes stored, err_ovf_o = 1, err_short_o = 0.
- cmd_len_i = 0 -> m_enable_o never asserts, err_len_o = 1, done_o 2 cycles after accept.
- rstn_i pulled low during RUN of a 3-byte write -> outputs return to reset values and cmd_ready_o = 1; a following 1-byte write completes cleanly.

Source files
------------

// File: rtl/i2c_xfer_ctrl.sv
// Transfer controller in front of the I2C byte master. Launches one host command
// at a time, feeds write data from a TX FIFO and collects read data into an RX FIFO.
module i2c_xfer_ctrl #(
  parameter int FIFO_AW = 4
) (
  input  logic               clock_i,
  input  logic               rstn_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_rw_i,
  input  logic               cmd_ur_i,
  input  logic [6:0]         cmd_devadr_i,
  input  logic [7:0]         cmd_regadr_i,
  input  logic [15:0]        cmd_len_i,
  input  logic               tx_wr_i,
  input  logic [7:0]         tx_wdat_i,
  output logic               tx_full_o,
  output logic [FIFO_AW:0]   tx_level_o,
  input  logic               rx_rd_i,
  output logic [7:0]         rx_rdat_o,
  output logic               rx_empty_o,
  output logic [FIFO_AW:0]   rx_level_o,
  output logic               done_o,
  output logic               err_short_o,
  output logic               err_unf_o,
  output logic               err_ovf_o,
  output logic               err_len_o,
  output logic               m_enable_o,
  output logic               m_rw_o,
  output logic               m_ur_o,
  output logic [6:0]         m_devadr_o,
  output logic [7:0]         m_regadr_o,
  output logic [15:0]        m_datnum_o,
  output logic [7:0]         m_dat_o,
  input  logic [7:0]         m_dat_i,
  input  logic               m_busy_i,
  input  logic               m_dvalid_i,
  input  logic               m_newdat_i
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_e;
  state_e state_q, state_d;

  logic        rw_q, ur_q;
  logic [6:0]  devadr_q;
  logic [7:0]  regadr_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q, cnt_d;
  logic        short_q, short_d, unf_q, unf_d, ovf_q, ovf_d, elen_q, elen_d;
  logic        done_q, done_d;
  logic        newdat_q, dvalid_q, busy_q;

  logic accept, in_run, wr_strobe, rd_strobe, busy_fall;

  logic [7:0]       tx_mem_q [DEPTH];
  logic [FIFO_AW:0] tx_wp_q, tx_rp_q;
  logic             tx_empty, tx_full, tx_push, tx_pop;

  logic [7:0]       rx_mem_q [DEPTH];
  logic [FIFO_AW:0] rx_wp_q, rx_rp_q;
  logic             rx_empty, rx_full, rx_push, rx_pop;

  assign accept    = cmd_valid_i && (state_q == IDLE);
  assign in_run    = (state_q == RUN);
  assign wr_strobe = in_run && !rw_q && m_newdat_i && !newdat_q;
  assign rd_strobe = in_run && rw_q && m_dvalid_i && !dvalid_q;
  assign busy_fall = busy_q && !m_busy_i;

  // TX FIFO: host pushes, master strobes pop; pop on empty leaves the head stale
  assign tx_level_o = tx_wp_q - tx_rp_q;
  assign tx_empty   = (tx_wp_q == tx_rp_q);
  assign tx_full    = tx_level_o[FIFO_AW];
  assign tx_push    = tx_wr_i && !tx_full;
  assign tx_pop     = wr_strobe && !tx_empty;
  assign tx_full_o  = tx_full;
  assign m_dat_o    = tx_mem_q[tx_rp_q[FIFO_AW-1:0]];

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) tx_mem_q[i] <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wp_q[FIFO_AW-1:0]] <= tx_wdat_i;
        tx_wp_q <= tx_wp_q + PTR_ONE;
      end
      if (tx_pop) tx_rp_q <= tx_rp_q + PTR_ONE;
    end
  end

  // RX FIFO: master strobes push (dropped when full), host pops
  assign rx_level_o = rx_wp_q - rx_rp_q;
  assign rx_empty   = (rx_wp_q == rx_rp_q);
  assign rx_full    = rx_level_o[FIFO_AW];
  assign rx_push    = rd_strobe && !rx_full;
  assign rx_pop     = rx_rd_i && !rx_empty;
  assign rx_empty_o = rx_empty;
  assign rx_rdat_o  = rx_mem_q[rx_rp_q[FIFO_AW-1:0]];

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) rx_mem_q[i] <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (rx_push) begin
        rx_mem_q[rx_wp_q[FIFO_AW-1:0]] <= m_dat_i;
        rx_wp_q <= rx_wp_q + PTR_ONE;
      end
      if (rx_pop) rx_rp_q <= rx_rp_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rw_q     <= 1'b0;
      ur_q     <= 1'b0;
      devadr_q <= '0;
      regadr_q <= '0;
      len_q    <= '0;
    end else if (accept) begin
      rw_q     <= cmd_rw_i;
      ur_q     <= cmd_ur_i;
      devadr_q <= cmd_devadr_i;
      regadr_q <= cmd_regadr_i;
      len_q    <= cmd_len_i;
    end
  end

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
      elen_q   <= 1'b0;
      done_q   <= 1'b0;
      newdat_q <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
      elen_q   <= elen_d;
      done_q   <= done_d;
      newdat_q <= m_newdat_i;
      dvalid_q <= m_dvalid_i;
      busy_q   <= m_busy_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = short_q;
    unf_d   = unf_q;
    ovf_d   = ovf_q;
    elen_d  = elen_q;
    done_d  = (state_q == FINISH) && !done_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          short_d = 1'b0;
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
          elen_d  = (cmd_len_i == '0);
          state_d = (cmd_len_i == '0) ? FINISH : LAUNCH;
        end
      end
      LAUNCH: if (m_enable_o && m_busy_i) state_d = RUN;
      RUN: begin
        if ((wr_strobe || rd_strobe) && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (wr_strobe && tx_empty) unf_d = 1'b1;
        if (rd_strobe && rx_full)  ovf_d = 1'b1;
        // a NACK on address or a middle byte ends the transfer early
        if (busy_fall) begin
          state_d = FINISH;
          if (cnt_d < len_q) short_d = 1'b1;
        end
      end
      FINISH: if (done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // writes hold off enable until there is something for the master to send
  assign m_enable_o  = (state_q == LAUNCH) && (rw_q || !tx_empty);
  assign cmd_ready_o = (state_q == IDLE);
  assign done_o      = done_q;
  assign err_short_o = short_q;
  assign err_unf_o   = unf_q;
  assign err_ovf_o   = ovf_q;
  assign err_len_o   = elen_q;
  assign m_rw_o      = rw_q;
  assign m_ur_o      = ur_q;
  assign m_devadr_o  = devadr_q;
  assign m_regadr_o  = regadr_q;
  assign m_datnum_o  = len_q;

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Bench for i2c_xfer_ctrl: directed table, corner sequences and random transfers
// against queue-based FIFO/slave model.
module tb_i2c_xfer_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0, cmd_ur = 1'b0;
  logic [6:0]    cmd_dev = '0;
  logic [7:0]    cmd_ra = '0;
  logic [15:0]   cmd_len = '0;
  logic          tx_wr = 1'b0, tx_full;
  logic [7:0]    tx_wdat = '0;
  logic [AW:0]   tx_level, rx_level;
  logic          rx_rd = 1'b0, rx_empty;
  logic [7:0]    rx_rdat;
  logic          done, e_short, e_unf, e_ovf, e_len;
  logic          m_en, m_rw, m_ur;
  logic [6:0]    m_dev;
  logic [7:0]    m_ra, m_dat_o;
  logic [15:0]   m_num;
  logic [7:0]    m_dat_i = '0;
  logic          m_busy = 1'b0, m_dvalid = 1'b0, m_newdat = 1'b0;

  i2c_xfer_ctrl #(.FIFO_AW(AW)) dut (
    .clock_i(clk), .rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rw_i(cmd_rw), .cmd_ur_i(cmd_ur),
    .cmd_devadr_i(cmd_dev), .cmd_regadr_i(cmd_ra), .cmd_len_i(cmd_len),
    .tx_wr_i(tx_wr), .tx_wdat_i(tx_wdat), .tx_full_o(tx_full), .tx_level_o(tx_level),
    .rx_rd_i(rx_rd), .rx_rdat_o(rx_rdat), .rx_empty_o(rx_empty), .rx_level_o(rx_level),
    .done_o(done), .err_short_o(e_short), .err_unf_o(e_unf), .err_ovf_o(e_ovf), .err_len_o(e_len),
    .m_enable_o(m_en), .m_rw_o(m_rw), .m_ur_o(m_ur), .m_devadr_o(m_dev), .m_regadr_o(m_ra),
    .m_datnum_o(m_num), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_busy_i(m_busy), .m_dvalid_i(m_dvalid), .m_newdat_i(m_newdat)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rd_src[$];

  typedef struct {
    logic rw, ur;
    logic [6:0] dev;
    logic [7:0] ra;
    int len, nact, pre;
    logic es, eu, eo, el;
    int rxl, txl;
  } vec_t;
  vec_t tbl[7];

  function automatic vec_t mk(logic rw, logic ur, logic [6:0] dev, logic [7:0] ra, int len,
                              int nact, int pre, logic es, logic eu, logic eo, logic el,
                              int rxl, int txl);
    vec_t v;
    v.rw = rw; v.ur = ur; v.dev = dev; v.ra = ra; v.len = len; v.nact = nact; v.pre = pre;
    v.es = es; v.eu = eu; v.eo = eo; v.el = el; v.rxl = rxl; v.txl = txl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1; tx_wdat = b;
    @(negedge clk);
    tx_wr = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
  endtask

  task automatic drain_rx();
    chk("rx_level", rx_level, rx_q.size());
    while (rx_q.size() > 0) begin
      chk("rx_data", rx_rdat, rx_q.pop_front());
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
    chk("rx_empty", rx_empty, 1);
  endtask

  // Issue a command and play the master: nact byte strobes, then busy falls.
  task automatic xfer(input logic rw, input logic ur, input logic [6:0] dev, input logic [7:0] ra,
                      input int len, input int nact, output logic [3:0] flags);
    logic [7:0] exp_tx[$];
    logic [7:0] seen[$];
    exp_tx = tx_q;
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_ur = ur; cmd_dev = dev; cmd_ra = ra; cmd_len = len[15:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_low", cmd_ready, 0);
    if (len == 0) begin
      chk("len0_en", m_en, 0);
      chk("len0_done_early", done, 0);
      @(negedge clk);
      chk("len0_en2", m_en, 0);
      chk("len0_done", done, 1);
    end else begin
      chk("en_lat", m_en, 1);
      chk("m_fields", {m_rw, m_ur, m_dev, m_ra}, {rw, ur, dev, ra});
      chk("m_datnum", m_num, len);
      if (!rw) seen.push_back(m_dat_o);
      m_busy = 1'b1;
      @(negedge clk);
      chk("en_drop", m_en, 0);
      for (int i = 0; i < nact; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (rw) begin m_dat_i = rd_src[i]; m_dvalid = 1'b1; end
        else m_newdat = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        m_dvalid = 1'b0; m_newdat = 1'b0;
        if (rw) begin
          if (rx_q.size() < DEPTH) rx_q.push_back(rd_src[i]);
        end else if (tx_q.size() > 0) void'(tx_q.pop_front());
        @(negedge clk);
        if (!rw && i < nact - 1) seen.push_back(m_dat_o);
      end
      for (int j = 0; j < seen.size() && j < exp_tx.size(); j++) chk("slave_byte", seen[j], exp_tx[j]);
      m_busy = 1'b0;
      @(negedge clk);
      chk("done_early", done, 0);
      @(negedge clk);
      chk("done_lat", done, 1);
    end
    flags = {e_len, e_ovf, e_unf, e_short};
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_back", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] flags;
    logic [7:0] b;
    vec_t v;
    tbl[0] = mk(0, 0, 7'h50, 8'h10, 3, 3, 3,   0, 0, 0, 0,  0, 0);
    tbl[1] = mk(1, 1, 7'h50, 8'h20, 4, 4, 0,   0, 0, 0, 0,  4, 0);
    tbl[2] = mk(1, 1, 7'h3C, 8'h00, 2, 0, 0,   1, 0, 0, 0,  0, 0);
    tbl[3] = mk(1, 0, 7'h50, 8'h00, 20, 20, 0, 0, 0, 1, 0, 16, 0);
    tbl[4] = mk(0, 0, 7'h50, 8'h10, 0, 0, 0,   0, 0, 0, 1,  0, 0);
    tbl[5] = mk(0, 1, 7'h48, 8'h7F, 3, 3, 2,   0, 1, 0, 0,  0, 0);
    tbl[6] = mk(0, 0, 7'h50, 8'h10, 2, 1, 2,   1, 0, 0, 0,  0, 1);

    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_fifo", {rx_empty, tx_full, tx_level, rx_level}, {1'b1, 1'b0, 5'd0, 5'd0});
    chk("rst_ctl", {m_en, done, e_short, e_unf, e_ovf, e_len, m_rw, m_ur}, 8'h00);
    chk("rst_fields", {m_dev, m_ra, m_dat_o}, 23'd0);
    chk("rst_num", m_num, 0);
    rstn = 1'b1;
    @(negedge clk);

    // write with empty TX waits for data before enabling the master
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_ur = 1'b0; cmd_dev = 7'h22; cmd_ra = 8'h01; cmd_len = 16'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) begin chk("wait_tx_en", m_en, 0); @(negedge clk); end
    push_tx(8'h5A);
    chk("late_en", m_en, 1);
    chk("late_dat", m_dat_o, 8'h5A);
    m_busy = 1'b1;
    @(negedge clk);
    chk("late_en_drop", m_en, 0);
    m_newdat = 1'b1;
    @(negedge clk);
    m_newdat = 1'b0;
    void'(tx_q.pop_front());
    chk("late_pop", tx_level, 0);
    m_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_done", done, 1);
    chk("late_flags", {e_len, e_ovf, e_unf, e_short}, 0);
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      v = tbl[k];
      for (int i = 0; i < v.pre; i++) begin b = 8'(8'hA1 + i); push_tx(b); end
      rd_src.delete();
      for (int i = 0; i < v.len; i++) begin b = 8'((i + 1) * 17); rd_src.push_back(b); end
      xfer(v.rw, v.ur, v.dev, v.ra, v.len, v.nact, flags);
      chk("tbl_flags", flags, {v.el, v.eo, v.eu, v.es});
      chk("tbl_txlvl", tx_level, v.txl);
      chk("tbl_rxlvl", rx_level, v.rxl);
      drain_rx();
    end

    // pushes beyond full are ignored; one write then consumes the whole FIFO
    for (int i = 0; i < DEPTH + 1; i++) begin b = 8'(8'hC0 + i); push_tx(b); end
    chk("tx_full", tx_full, 1);
    chk("tx_full_lvl", tx_level, DEPTH);
    xfer(0, 0, 7'h11, 8'h22, DEPTH, DEPTH, flags);
    chk("full_flags", flags, 0);
    chk("full_drained", tx_level, 0);

    for (int it = 0; it < 30; it++) begin
      logic rw;
      int len, nact, txs, rxs, npre;
      logic [3:0] exp;
      rw   = 1'($urandom_range(0, 1));
      len  = rw ? $urandom_range(1, 20) : $urandom_range(1, 6);
      nact = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : len;
      if (!rw) begin
        npre = $urandom_range((tx_q.size() == 0) ? 1 : 0, 4);
        for (int i = 0; i < npre; i++) push_tx(8'($urandom));
      end
      rd_src.delete();
      for (int i = 0; i < len; i++) rd_src.push_back(8'($urandom));
      txs = tx_q.size();
      rxs = rx_q.size();
      exp = {1'b0, rw && (nact > DEPTH - rxs), !rw && (nact > txs), nact < len};
      xfer(rw, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), len, nact, flags);
      chk("rnd_flags", flags, exp);
      chk("rnd_txlvl", tx_level, tx_q.size());
      if ($urandom_range(0, 1) == 1) drain_rx();
      else chk("rnd_rxlvl", rx_level, rx_q.size());
    end
    drain_rx();

    // reset in the middle of a 3-byte write
    for (int i = 0; i < 3; i++) begin b = 8'(8'h31 + i); push_tx(b); end
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev = 7'h50; cmd_ra = 8'h10; cmd_len = 16'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    m_busy = 1'b1;
    @(negedge clk);
    m_newdat = 1'b1;
    @(negedge clk);
    m_newdat = 1'b0;
    @(negedge clk);
    chk("mid_lvl", tx_level, 2);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_fifo", {rx_empty, tx_full, tx_level, rx_level}, {1'b1, 1'b0, 5'd0, 5'd0});
    chk("mrst_ctl", {m_en, done, e_short, e_unf, e_ovf, e_len, m_rw, m_ur}, 8'h00);
    chk("mrst_fields", {m_dev, m_ra, m_dat_o}, 23'd0);
    m_busy = 1'b0;
    tx_q.delete();
    rx_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push_tx(8'h77);
    xfer(0, 0, 7'h50, 8'h10, 1, 1, flags);
    chk("post_rst_flags", flags, 0);
    chk("post_rst_txlvl", tx_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
